mux_lut_pipe: RTL

MUX_LUT_PIPE -- requirements
Module: mux_lut_pipe

---
 rtl/mux_lut_pkg.sv | 20 ++
 rtl/mux_lut_pipe_mux2.sv | 11 +
 rtl/mux_lut_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/mux_lut_pkg.sv
// Shared constants and types for the LUT/reduction pipeline.
package mux_lut_pkg;

  // Common truth tables, indexed by {b, a}.
  localparam logic [3:0] TT_AND    = 4'b1000;
  localparam logic [3:0] TT_OR     = 4'b1110;
  localparam logic [3:0] TT_XOR    = 4'b0110;
  localparam logic [3:0] TT_NAND   = 4'b0111;
  localparam logic [3:0] TT_NOR    = 4'b0001;
  localparam logic [3:0] TT_PASS_A = 4'b1010;

  // Reduction applied to the LUT vector in the second stage.
  typedef enum logic [1:0] {
    RED_NONE = 2'd0,
    RED_OR   = 2'd1,
    RED_AND  = 2'd2,
    RED_XOR  = 2'd3
  } red_e;

endpackage

// File: rtl/mux_lut_pipe_mux2.sv
// Single-bit 2-input multiplexer; the building block for all selection logic.
module mux_lut_pipe_mux2 (
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux_lut_pipe.sv
// Two-stage valid/ready pipeline: S1 captures the per-bit truth-table
// lookup, S2 registers either the raw vector or a 1-bit reduction of it.
module mux_lut_pipe
  import mux_lut_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       tt,
  input  logic [1:0]       red,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] res
);

  logic             w_adv;
  logic [WIDTH-1:0] w_lut_lo;
  logic [WIDTH-1:0] w_lut_hi;
  logic [WIDTH-1:0] w_v;
  logic [WIDTH-1:0] w_s2_d;
  logic [1:0]       w_s1_red_bits;
  logic             w_red_any;
  logic             w_red_or;
  logic             w_red_and;
  logic             w_red_xor;
  logic             w_b0_lo;
  logic             w_b0_hi;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_v;
  red_e             r_s1_red;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_res;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign w_adv      = !r_s2_valid || down_ready;
  assign up_ready   = w_adv;
  assign down_valid = r_s2_valid;
  assign res        = r_s2_res;

  // Per-bit lookup: a[i] picks within each half of tt, b[i] picks the half.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lut
    mux_lut_pipe_mux2 u_lo  (.i_d0(tt[0]),        .i_d1(tt[1]),        .i_sel(a[gi]), .o_y(w_lut_lo[gi]));
    mux_lut_pipe_mux2 u_hi  (.i_d0(tt[2]),        .i_d1(tt[3]),        .i_sel(a[gi]), .o_y(w_lut_hi[gi]));
    mux_lut_pipe_mux2 u_sel (.i_d0(w_lut_lo[gi]), .i_d1(w_lut_hi[gi]), .i_sel(b[gi]), .o_y(w_v[gi]));
  end

  assign w_s1_red_bits = r_s1_red;
  assign w_red_any     = (r_s1_red != RED_NONE);
  assign w_red_or      = |r_s1_v;
  assign w_red_and     = &r_s1_v;
  assign w_red_xor     = ^r_s1_v;

  // Bit 0 picks among raw/OR/AND/XOR by the two mode bits.
  mux_lut_pipe_mux2 u_b0_lo (.i_d0(r_s1_v[0]), .i_d1(w_red_or),  .i_sel(w_s1_red_bits[0]), .o_y(w_b0_lo));
  mux_lut_pipe_mux2 u_b0_hi (.i_d0(w_red_and), .i_d1(w_red_xor), .i_sel(w_s1_red_bits[0]), .o_y(w_b0_hi));
  mux_lut_pipe_mux2 u_b0    (.i_d0(w_b0_lo),   .i_d1(w_b0_hi),   .i_sel(w_s1_red_bits[1]), .o_y(w_s2_d[0]));

  // Upper bits pass the raw vector only when no reduction is selected.
  for (genvar gj = 1; gj < WIDTH; gj++) begin : g_upper
    mux_lut_pipe_mux2 u_up (.i_d0(r_s1_v[gj]), .i_d1(1'b0), .i_sel(w_red_any), .o_y(w_s2_d[gj]));
  end

  // Valid bits and the output register: cleared by reset, otherwise advance as one.
  // NOTE: non-blocking assignments let S2 see S1's old value on the same edge S1 reloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= up_valid;
      r_s2_valid <= r_s1_valid;
      r_s2_res   <= w_s2_d;
    end
  end

  // S1 payload capture.
  // NOTE: payload needs no reset; its valid bit alone decides whether it means anything.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_v   <= w_v;
      r_s1_red <= red_e'(red);
    end
  end

endmodule
